// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: request FSM states and the
// packed width of one fetch-queue entry {pc, inst, taken, pcPred}.
package if_fetch_queue_pkg;

  typedef enum logic {
    FQ_IDLE = 1'b0,
    FQ_WAIT = 1'b1
  } fq_state_e;

  function automatic int entry_width(input int addr_w, input int inst_w);
    return 2 * addr_w + inst_w + 1;
  endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// DEPTH-entry circular fetch queue with push/pop/flush. The head payload is a
// register-file read addressed by registered pointers and reads as zero when empty.
module if_fetch_queue_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (en_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i && do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = empty;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: PC generator, single-outstanding I-cache request FSM
// with BTB capture, and a fetch queue that keeps prefetching while decode stalls.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          INST_W    = 32,
  parameter int          IC_ADDR_W = 18,
  parameter int          DEPTH     = 4,
  parameter int          PCSTEP    = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    pcJump_in,
  input  logic [ADDR_W-1:0]       pcTarget_in,
  input  logic                    MEM_MCAccess_in,
  output logic                    ICache_out,
  output logic [IC_ADDR_W-1:0]    ICacheAddr_out,
  input  logic                    instE_in,
  input  logic [INST_W-1:0]       inst_in,
  output logic [ADDR_W-1:0]       IF_BTB_pc_out,
  input  logic                    IF_BTB_taken_in,
  input  logic [ADDR_W-1:0]       IF_BTB_pcPred_in,
  input  logic                    id_ready_in,
  output logic                    instE_out,
  output logic [ADDR_W-1:0]       IF_pc_out,
  output logic [INST_W-1:0]       inst_out,
  output logic                    IF_taken_out,
  output logic [ADDR_W-1:0]       IF_pcPred_out,
  output logic [$clog2(DEPTH):0]  q_count_out
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = entry_width(ADDR_W, INST_W);
  localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);

  fq_state_e            state_q;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 drop_q;
  logic                 icache_q;
  logic [IC_ADDR_W-1:0] icache_addr_q;
  logic [ADDR_W-1:0]    lat_pc_q, lat_pred_q;
  logic                 lat_taken_q;

  logic                 resp, issue, push, pop;
  logic [CNT_W:0]       reserved;
  logic [CNT_W-1:0]     count;
  logic                 empty;
  logic [ENTRY_W-1:0]   push_entry, head_entry;

  // A request still in flight owns a queue slot unless its data is to be dropped.
  always_comb begin
    resp     = (state_q == FQ_WAIT) & instE_in;
    reserved = {1'b0, count} + (CNT_W+1)'((state_q == FQ_WAIT) && !drop_q);
    issue    = ~pcJump_in & ~MEM_MCAccess_in
             & ((state_q == FQ_IDLE) | resp)
             & (reserved < (CNT_W+1)'(DEPTH));
    push     = resp & ~drop_q & ~pcJump_in;
    pop      = ~empty & id_ready_in & ~pcJump_in;
    pc_d     = IF_BTB_taken_in ? IF_BTB_pcPred_in : pc_q + ADDR_W'(PCSTEP);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= FQ_IDLE;
      pc_q          <= RESET_PC_L;
      drop_q        <= 1'b0;
      icache_q      <= 1'b0;
      icache_addr_q <= '0;
    end else if (rdy_in) begin
      icache_q <= 1'b0;
      if (pcJump_in) begin
        pc_q <= pcTarget_in;
        if (resp) begin
          state_q <= FQ_IDLE;
          drop_q  <= 1'b0;
        end else if (state_q == FQ_WAIT) begin
          drop_q  <= 1'b1;
        end
      end else begin
        if (resp) begin
          state_q <= FQ_IDLE;
          drop_q  <= 1'b0;
        end
        if (issue) begin
          state_q       <= FQ_WAIT;
          icache_q      <= 1'b1;
          icache_addr_q <= pc_q[IC_ADDR_W-1:0];
          pc_q          <= pc_d;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && issue) begin
      lat_pc_q    <= pc_q;
      lat_taken_q <= IF_BTB_taken_in;
      lat_pred_q  <= IF_BTB_pcPred_in;
    end
  end

  assign push_entry = {lat_pc_q, inst_in, lat_taken_q, lat_pred_q};

  if_fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .en_i    (rdy_in),
    .flush_i (pcJump_in),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .count_o (count),
    .empty_o (empty)
  );

  assign ICache_out     = icache_q;
  assign ICacheAddr_out = icache_addr_q;
  assign IF_BTB_pc_out  = pc_q;
  assign instE_out      = ~empty;
  assign q_count_out    = count;
  assign {IF_pc_out, inst_out, IF_taken_out, IF_pcPred_out} = head_entry;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a behavioural I-cache and BTB drive the
// DUT while a queue-based program-flow model predicts every request and head entry.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] pred;
  } ent_t;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, pcJump_in, MEM_MCAccess_in, instE_in, id_ready_in;
  logic [31:0] pcTarget_in, inst_in;
  logic        ICache_out, instE_out, IF_taken_out;
  logic [17:0] ICacheAddr_out;
  logic [31:0] IF_BTB_pc_out, IF_pc_out, inst_out, IF_pcPred_out;
  logic        IF_BTB_taken_in;
  logic [31:0] IF_BTB_pcPred_in;
  logic [2:0]  q_count_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  if_fetch_queue dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .pcJump_in        (pcJump_in),
    .pcTarget_in      (pcTarget_in),
    .MEM_MCAccess_in  (MEM_MCAccess_in),
    .ICache_out       (ICache_out),
    .ICacheAddr_out   (ICacheAddr_out),
    .instE_in         (instE_in),
    .inst_in          (inst_in),
    .IF_BTB_pc_out    (IF_BTB_pc_out),
    .IF_BTB_taken_in  (IF_BTB_taken_in),
    .IF_BTB_pcPred_in (IF_BTB_pcPred_in),
    .id_ready_in      (id_ready_in),
    .instE_out        (instE_out),
    .IF_pc_out        (IF_pc_out),
    .inst_out         (inst_out),
    .IF_taken_out     (IF_taken_out),
    .IF_pcPred_out    (IF_pcPred_out),
    .q_count_out      (q_count_out)
  );

  // Small static BTB: 0x8->0x40, 0x60->0x100, 0x118->0x8 forms a loop.
  function automatic logic [32:0] btb(input logic [31:0] pc);
    case (pc)
      32'h8:   return {1'b1, 32'h40};
      32'h60:  return {1'b1, 32'h100};
      32'h118: return {1'b1, 32'h8};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  function automatic logic [31:0] cache_data(input logic [17:0] a);
    return {14'h1ACE, a};
  endfunction

  assign {IF_BTB_taken_in, IF_BTB_pcPred_in} = btb(IF_BTB_pc_out);

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  ent_t        q[$];
  ent_t        req;
  logic [31:0] mpc;
  bit          busy, drop, exp_ic;
  logic [17:0] exp_addr;
  // Behavioural I-cache: one pending response with a countdown
  bit          c_valid;
  int          c_cnt;
  logic [17:0] c_addr;
  int          lat;

  initial begin
    bit          last_rdy, last_rst, in_rst, resp, can, start_rst;
    int          rst_left, reserved, pops;
    logic [32:0] b;

    rst_in = 1'b0; rdy_in = 1'b0; pcJump_in = 1'b0; pcTarget_in = '0;
    MEM_MCAccess_in = 1'b0; instE_in = 1'b0; inst_in = '0; id_ready_in = 1'b0;
    mpc = '0; busy = 0; drop = 0; exp_ic = 0; exp_addr = '0; req = '0;
    c_valid = 0; c_cnt = 0; c_addr = '0; lat = 1;
    last_rdy = 0; last_rst = 0; in_rst = 1; rst_left = 1; pops = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk_in);
      #1;
      // cache side: retire a consumed response, age a pending one, capture new strobes
      if (c_valid && last_rdy) begin
        if (c_cnt == 0) c_valid = 0;
        else            c_cnt--;
      end
      if (ICache_out === 1'b1 && last_rdy && last_rst) begin
        check_val("one_outstanding", 64'(c_valid), 64'd0);
        c_valid = 1; c_cnt = lat; c_addr = ICacheAddr_out;
      end

      // compare DUT against the model
      check_val("icache_req", 64'(ICache_out), 64'(exp_ic));
      if (exp_ic) check_val("icache_addr", 64'(ICacheAddr_out), 64'(exp_addr));
      if (!last_rst) check_val("rst_addr", 64'(ICacheAddr_out), 64'd0);
      check_val("btb_pc", 64'(IF_BTB_pc_out), 64'(mpc));
      check_val("q_count", 64'(q_count_out), 64'(q.size()));
      check_val("head_valid", 64'(instE_out), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check_val("head_pc", 64'(IF_pc_out), 64'(q[0].pc));
        check_val("head_inst", 64'(inst_out), 64'(q[0].inst));
        check_val("head_taken", 64'(IF_taken_out), 64'(q[0].taken));
        check_val("head_pred", 64'(IF_pcPred_out), 64'(q[0].pred));
      end else begin
        check_val("empty_payload", 64'(|{IF_pc_out, inst_out, IF_taken_out, IF_pcPred_out}), 64'd0);
      end
      if (cyc == 42) check_val("stall_full", 64'(q_count_out), 64'(DEPTH));
      if (cyc == 62) check_val("flush_empty", 64'(q_count_out), 64'd0);

      // stimulus knobs: directed phases first, then random traffic
      rdy_in = 1'b1; id_ready_in = 1'b1; MEM_MCAccess_in = 1'b0; pcJump_in = 1'b0;
      pcTarget_in = 32'($urandom_range(0, 127)) << 2;
      lat = 1; start_rst = 0;
      if (cyc < 90) begin
        if (cyc >= 30 && cyc <= 41) id_ready_in = 1'b0;
        if (cyc >= 50 && cyc <= 54) MEM_MCAccess_in = 1'b1;
        if (cyc >= 56 && cyc <= 61) id_ready_in = 1'b0;
        if (cyc == 61) begin pcJump_in = 1'b1; pcTarget_in = 32'h100; end
        if (cyc >= 64 && cyc <= 75) id_ready_in = 1'b0;
        if (cyc == 72) start_rst = 1;
      end else begin
        rdy_in          = ($urandom_range(0, 7) != 0);
        id_ready_in     = ((cyc % 200) >= 100 && (cyc % 200) < 115) ? 1'b0 : ($urandom_range(0, 3) != 0);
        MEM_MCAccess_in = ($urandom_range(0, 19) == 0);
        pcJump_in       = ($urandom_range(0, 29) == 0);
        lat             = $urandom_range(1, 3);
        start_rst       = ($urandom_range(0, 199) == 0);
      end
      if (start_rst && !in_rst) begin in_rst = 1; rst_left = 2; end
      if (in_rst && rst_left == 0 && !(c_valid && c_cnt > 0)) in_rst = 0;
      rst_in = !in_rst;
      if (in_rst && rst_left > 0) rst_left--;
      instE_in = c_valid && (c_cnt == 0);
      inst_in  = instE_in ? cache_data(c_addr) : $urandom;

      // model: what the coming edge must do
      if (!rst_in) begin
        q.delete(); mpc = '0; busy = 0; drop = 0; exp_ic = 0;
      end else if (rdy_in) begin
        resp = busy && instE_in;
        if (pcJump_in) begin
          q.delete();
          if (resp) begin busy = 0; drop = 0; end
          else if (busy) drop = 1;
          mpc = pcTarget_in; exp_ic = 0;
        end else begin
          reserved = q.size() + ((busy && !drop) ? 1 : 0);
          can = !MEM_MCAccess_in && (!busy || resp) && (reserved < DEPTH);
          if (q.size() != 0 && id_ready_in) begin void'(q.pop_front()); pops++; end
          if (resp) begin
            if (!drop) q.push_back(req);
            busy = 0; drop = 0;
          end
          exp_ic = can;
          if (can) begin
            b = btb(mpc);
            req = '{pc: mpc, inst: cache_data(mpc[17:0]), taken: b[32], pred: b[31:0]};
            busy = 1; exp_addr = mpc[17:0];
            mpc = b[32] ? b[31:0] : mpc + 32'd4;
          end
        end
      end
      last_rdy = rdy_in; last_rst = rst_in;
    end

    check_val("liveness", 64'(pops > 200), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
